// File: rtl/imem_wb_loader_if.sv
// Wishbone classic slave bundle for the instruction-memory loader window.
interface imem_wb_loader_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i,
        input  wbs_cyc_i,
        input  wbs_we_i,
        input  wbs_sel_i,
        input  wbs_adr_i,
        input  wbs_dat_i,
        output wbs_ack_o,
        output wbs_dat_o
    );

    modport master (
        output wbs_stb_i,
        output wbs_cyc_i,
        output wbs_we_i,
        output wbs_sel_i,
        output wbs_adr_i,
        output wbs_dat_i,
        input  wbs_ack_o,
        input  wbs_dat_o
    );
endinterface

// File: rtl/imem_wb_loader.sv
// Wishbone register window that loads the SLRV instruction SRAM and holds the core in reset.
// Define IMEM_READBACK_EN to let DATA reads fetch the word at ADDR from SRAM.
module imem_wb_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned AW        = 9
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    imem_wb_loader_if.slave      wbs,
    output logic                 sram_csb0,
    output logic                 sram_web0,
    output logic [3:0]           sram_wmask0,
    output logic [AW-1:0]        sram_addr0,
    output logic [31:0]          sram_din0,
    input  logic [31:0]          sram_dout0,
    output logic                 core_rst
);

    localparam int unsigned CNT_W   = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(512);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_ADDR   = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        RDW  = 3'd3,
        ACK  = 3'd4
    } state_e;

    state_e            state_q;
    logic              ack_q;
    logic [31:0]       dat_q;
    logic              csb_q;
    logic              web_q;
    logic [3:0]        wmask_q;
    logic [AW-1:0]     sram_addr_q;
    logic [31:0]       din_q;
    logic              ctrl_load_q;
    logic              ctrl_ainc_q;
    logic              core_rst_q;
    logic [AW-1:0]     addr_q;
    logic [CNT_W-1:0]  count_q;
    logic              wrap_q;
    logic              err_q;

    logic              hit_c;
    logic              accept_c;
    logic [1:0]        reg_sel_c;
    logic [AW-1:0]     addr_inc_c;
    logic              addr_last_c;
    logic              busy_c;
    logic [31:0]       rdata_c;
    logic              unused_c;

    // Decode: the window is 16 bytes, word-addressed by adr[3:2].
    assign hit_c       = (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign accept_c    = wbs.wbs_cyc_i & wbs.wbs_stb_i & hit_c & (state_q == IDLE);
    assign reg_sel_c   = wbs.wbs_adr_i[3:2];
    assign addr_inc_c  = addr_q + AW'(1);
    assign addr_last_c = &addr_q;
    assign busy_c      = (state_q != IDLE);
    assign unused_c    = ^wbs.wbs_adr_i[1:0];

    // Register read mux; DATA reads are handled by the FSM.
    always_comb begin
        rdata_c = 32'h0;
        case (reg_sel_c)
            REG_CTRL:   rdata_c = {30'h0, ctrl_ainc_q, ctrl_load_q};
            REG_ADDR:   rdata_c = 32'(addr_q);
            REG_DATA:   rdata_c = 32'h0;
            REG_STATUS: rdata_c = {13'h0, busy_c, err_q, wrap_q, 6'h0, count_q};
            default:    rdata_c = 32'h0;
        endcase
    end

    // Transfer FSM, register file and SRAM port drive.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            dat_q       <= 32'h0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            wmask_q     <= 4'h0;
            sram_addr_q <= '0;
            din_q       <= 32'h0;
            ctrl_load_q <= 1'b1;
            ctrl_ainc_q <= 1'b0;
            core_rst_q  <= 1'b1;
            addr_q      <= '0;
            count_q     <= '0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        case (reg_sel_c)
                            REG_CTRL: begin
                                if (wbs.wbs_we_i) begin
                                    ctrl_load_q <= wbs.wbs_dat_i[0];
                                    ctrl_ainc_q <= wbs.wbs_dat_i[1];
                                    core_rst_q  <= wbs.wbs_dat_i[0];
                                    if (wbs.wbs_dat_i[31]) begin
                                        count_q <= '0;
                                        wrap_q  <= 1'b0;
                                        err_q   <= 1'b0;
                                    end
                                end else begin
                                    dat_q <= rdata_c;
                                end
                                state_q <= ACK;
                                ack_q   <= 1'b1;
                            end
                            REG_ADDR: begin
                                if (wbs.wbs_we_i) begin
                                    addr_q <= wbs.wbs_dat_i[AW-1:0];
                                end else begin
                                    dat_q <= rdata_c;
                                end
                                state_q <= ACK;
                                ack_q   <= 1'b1;
                            end
                            REG_DATA: begin
                                if (wbs.wbs_we_i) begin
                                    if (ctrl_load_q) begin
                                        csb_q       <= 1'b0;
                                        web_q       <= 1'b0;
                                        wmask_q     <= wbs.wbs_sel_i;
                                        sram_addr_q <= addr_q;
                                        din_q       <= wbs.wbs_dat_i;
                                        state_q     <= WR;
                                    end else begin
                                        // Rejected load still advances ADDR so software stays in step.
                                        err_q   <= 1'b1;
                                        state_q <= ACK;
                                        ack_q   <= 1'b1;
                                        if (ctrl_ainc_q) begin
                                            addr_q <= addr_inc_c;
                                            if (addr_last_c) begin
                                                wrap_q <= 1'b1;
                                            end
                                        end
                                    end
                                end else begin
`ifdef IMEM_READBACK_EN
                                    csb_q       <= 1'b0;
                                    web_q       <= 1'b1;
                                    sram_addr_q <= addr_q;
                                    state_q     <= RD;
`else
                                    dat_q   <= 32'h0;
                                    state_q <= ACK;
                                    ack_q   <= 1'b1;
`endif
                                end
                            end
                            default: begin
                                if (!wbs.wbs_we_i) begin
                                    dat_q <= rdata_c;
                                end
                                state_q <= ACK;
                                ack_q   <= 1'b1;
                            end
                        endcase
                    end
                end
                WR: begin
                    csb_q   <= 1'b1;
                    web_q   <= 1'b1;
                    wmask_q <= 4'h0;
                    if (count_q != CNT_MAX) begin
                        count_q <= count_q + CNT_W'(1);
                    end
                    if (ctrl_ainc_q) begin
                        addr_q <= addr_inc_c;
                        if (addr_last_c) begin
                            wrap_q <= 1'b1;
                        end
                    end
                    state_q <= ACK;
                    ack_q   <= 1'b1;
                end
                RD: begin
                    csb_q <= 1'b1;
                    if (ctrl_ainc_q) begin
                        addr_q <= addr_inc_c;
                        if (addr_last_c) begin
                            wrap_q <= 1'b1;
                        end
                    end
                    state_q <= RDW;
                end
                RDW: begin
                    // SRAM output is valid the cycle after the read strobe.
                    dat_q   <= sram_dout0;
                    state_q <= ACK;
                    ack_q   <= 1'b1;
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign sram_csb0     = csb_q;
    assign sram_web0     = web_q;
    assign sram_wmask0   = wmask_q;
    assign sram_addr0    = sram_addr_q;
    assign sram_din0     = din_q;
    assign core_rst      = core_rst_q;

endmodule

// File: tb/tb_imem_wb_loader.sv
// Scoreboard bench for imem_wb_loader: random Wishbone traffic against a register/array model.
module tb_imem_wb_loader;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int unsigned AW    = 9;
    localparam int          DEPTH = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_wb_loader_if wbs ();
    logic          sram_csb0, sram_web0, core_rst;
    logic [3:0]    sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [31:0]   sram_din0;
    logic [31:0]   sram_dout0 = 32'h0;

    imem_wb_loader #(.BASE_ADDR(BASE), .AW(AW)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbs         (wbs),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0),
        .core_rst    (core_rst)
    );

    // Behavioural single-port SRAM macro
    logic [31:0] sram_arr [DEPTH] = '{default: 32'h0};
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask0[b]) sram_arr[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
            end else begin
                sram_dout0 <= sram_arr[sram_addr0];
            end
        end
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct { logic [31:0] data; bit chk; int lat; int issue; string name; } exp_t;
    typedef struct { logic [AW-1:0] addr; logic [31:0] din; logic [3:0] mask; } sram_t;
    exp_t          exp_q[$];
    sram_t         wr_q[$];
    logic [AW-1:0] rd_q[$];

    // Reference model state
    logic [31:0] mem_m [DEPTH] = '{default: 32'h0};
    bit m_load, m_ainc, m_wrap, m_err;
    int m_addr, m_cnt;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    function automatic void model_reset();
        m_load = 1'b1; m_ainc = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
        m_addr = 0; m_cnt = 0;
    endfunction

    function automatic void model_advance();
        if (m_ainc) begin
            m_addr = (m_addr + 1) % DEPTH;
            if (m_addr == 0) m_wrap = 1'b1;
        end
    endfunction

    // Monitor: pops expectations whenever the DUT acks or strobes the SRAM
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wbs.wbs_ack_o) begin
                    exp_t e;
                    if (exp_q.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        check({e.name, "_lat"}, 32'(cyc_cnt - e.issue), 32'(e.lat));
                        if (e.chk) check({e.name, "_data"}, wbs.wbs_dat_o, e.data);
                    end
                end
                if (!sram_csb0 && !sram_web0) begin
                    sram_t s;
                    if (wr_q.size() == 0) check("unexpected_sram_write", 32'd1, 32'd0);
                    else begin
                        s = wr_q.pop_front();
                        check("sram_wr_addr", 32'(sram_addr0), 32'(s.addr));
                        check("sram_wr_din", sram_din0, s.din);
                        check("sram_wr_mask", 32'(sram_wmask0), 32'(s.mask));
                    end
                end
                if (!sram_csb0 && sram_web0) begin
                    logic [AW-1:0] ra;
                    if (rd_q.size() == 0) check("unexpected_sram_read", 32'd1, 32'd0);
                    else begin
                        ra = rd_q.pop_front();
                        check("sram_rd_addr", 32'(sram_addr0), 32'(ra));
                    end
                end
            end
        end
    end

    task automatic bus_idle();
        wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
        wbs.wbs_sel_i = 4'h0; wbs.wbs_adr_i = 32'h0; wbs.wbs_dat_i = 32'h0;
    endtask

    task automatic xfer(input bit we, input int r, input logic [31:0] d, input logic [3:0] sel, input bit drop);
        exp_t e;
        sram_t s;
        bit got;
        @(posedge clk); #1;
        e.chk = 1'b0; e.data = 32'h0; e.lat = 1;
        e.name = $sformatf("%s_%0d", we ? "wr" : "rd", r);
        case (r)
            0: if (we) begin
                   m_load = d[0]; m_ainc = d[1];
                   if (d[31]) begin m_cnt = 0; m_wrap = 1'b0; m_err = 1'b0; end
               end else begin
                   e.chk = 1'b1; e.data = {30'h0, m_ainc, m_load};
               end
            1: if (we) m_addr = int'(d[AW-1:0]);
               else begin e.chk = 1'b1; e.data = 32'(m_addr); end
            2: if (we) begin
                   if (m_load) begin
                       s.addr = AW'(m_addr); s.din = d; s.mask = sel;
                       wr_q.push_back(s);
                       for (int b = 0; b < 4; b++)
                           if (sel[b]) mem_m[m_addr][8*b +: 8] = d[8*b +: 8];
                       if (m_cnt < 512) m_cnt++;
                       e.lat = 2;
                   end else begin
                       m_err = 1'b1;
                   end
                   model_advance();
               end else begin
`ifdef IMEM_READBACK_EN
                   e.chk = 1'b1; e.data = mem_m[m_addr]; e.lat = 3;
                   rd_q.push_back(AW'(m_addr));
                   model_advance();
`else
                   e.chk = 1'b1; e.data = 32'h0;
`endif
               end
            default: if (!we) begin
                   e.chk = 1'b1;
                   e.data = {13'h0, 1'b0, m_err, m_wrap, 6'h0, 10'(m_cnt)};
               end
        endcase
        e.issue = cyc_cnt;
        exp_q.push_back(e);
        wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = we;
        wbs.wbs_sel_i = sel; wbs.wbs_adr_i = BASE + 32'(r * 4); wbs.wbs_dat_i = d;
        if (drop) begin
            @(posedge clk); #1;
            wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wbs.wbs_ack_o) begin got = 1'b1; break; end
        end
        bus_idle();
        check({e.name, "_ack_seen"}, 32'(got), 32'd1);
        if (!got && exp_q.size() != 0) void'(exp_q.pop_back());
        check({e.name, "_core_rst"}, 32'(core_rst), 32'(m_load));
    endtask

    task automatic no_hit(input logic [31:0] a);
        bit seen = 1'b0;
        @(posedge clk); #1;
        wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = 1'b0; wbs.wbs_adr_i = a;
        repeat (6) begin
            @(negedge clk);
            if (wbs.wbs_ack_o) seen = 1'b1;
        end
        bus_idle();
        check("out_of_window_ack", 32'(seen), 32'd0);
    endtask

    task automatic reset_in_wr();
        @(posedge clk); #1;
        wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = 1'b1;
        wbs.wbs_sel_i = 4'hF; wbs.wbs_adr_i = BASE + 32'd8; wbs.wbs_dat_i = 32'hA5A5_5A5A;
        @(posedge clk); #2;
        check("wr_strobe_before_rst", 32'(sram_csb0), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_csb0", 32'(sram_csb0), 32'd1);
        check("rst_web0", 32'(sram_web0), 32'd1);
        check("rst_ack", 32'(wbs.wbs_ack_o), 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        bus_idle();
        repeat (3) begin
            @(negedge clk);
            check("ack_during_rst", 32'(wbs.wbs_ack_o), 32'd0);
        end
        exp_q.delete(); wr_q.delete(); rd_q.delete();
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_idle();
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_csb0", 32'(sram_csb0), 32'd1);
        check("reset_web0", 32'(sram_web0), 32'd1);
        check("reset_wmask0", 32'(sram_wmask0), 32'd0);
        check("reset_addr0", 32'(sram_addr0), 32'd0);
        check("reset_din0", sram_din0, 32'd0);
        check("reset_ack", 32'(wbs.wbs_ack_o), 32'd0);
        check("reset_dat_o", wbs.wbs_dat_o, 32'd0);
        check("reset_core_rst", 32'(core_rst), 32'd1);

        xfer(0, 0, 32'h0, 4'hF, 0);
        // Basic load at address 5 with autoincrement
        xfer(1, 1, 32'd5, 4'hF, 0);
        xfer(1, 0, 32'd3, 4'hF, 0);
        xfer(1, 2, 32'h0000_0013, 4'hF, 0);
        xfer(0, 1, 32'h0, 4'hF, 0);
        xfer(0, 3, 32'h0, 4'hF, 0);
        // Wrap from the top of the store
        xfer(1, 1, 32'd511, 4'hF, 0);
        xfer(1, 2, 32'h1111_2222, 4'hF, 0);
        xfer(1, 2, 32'h3333_4444, 4'h5, 0);
        xfer(0, 3, 32'h0, 4'hF, 0);
        xfer(0, 1, 32'h0, 4'hF, 0);
        // Release the core, then a rejected load
        xfer(1, 0, 32'h0, 4'hF, 0);
        xfer(1, 2, 32'hBAD0_BAD0, 4'hF, 0);
        xfer(0, 3, 32'h0, 4'hF, 0);
        xfer(1, 0, 32'h8000_0001, 4'hF, 0);
        xfer(0, 3, 32'h0, 4'hF, 0);
        // Readback of a known word
        xfer(1, 1, 32'd7, 4'hF, 0);
        xfer(1, 2, 32'hDEAD_BEEF, 4'hF, 0);
        xfer(1, 1, 32'd7, 4'hF, 0);
        xfer(0, 2, 32'h0, 4'hF, 0);
        xfer(0, 1, 32'h0, 4'hF, 0);
        // Master abandons the cycle; sequence must still finish
        xfer(1, 0, 32'd3, 4'hF, 0);
        xfer(1, 2, 32'hCAFE_F00D, 4'hF, 1);
        xfer(0, 1, 32'h0, 4'hF, 1);
        xfer(1, 3, 32'hFFFF_FFFF, 4'hF, 0);
        xfer(0, 3, 32'h0, 4'hF, 0);
        no_hit(BASE + 32'd16);
        no_hit(BASE - 32'd4);
        xfer(1, 0, 32'd1, 4'hF, 0);
        reset_in_wr();
        xfer(0, 0, 32'h0, 4'hF, 0);

        for (int n = 0; n < 250; n++) begin
            int r;
            bit we;
            logic [31:0] d;
            r  = int'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            d  = $urandom;
            if (r == 0) d[0] = ($urandom_range(0, 3) != 0);
            xfer(we, r, d, 4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
        end

        // Saturation of the word count
        xfer(1, 0, 32'h8000_0003, 4'hF, 0);
        for (int n = 0; n < 515; n++) xfer(1, 2, $urandom, 4'hF, 0);
        xfer(0, 3, 32'h0, 4'hF, 0);

        repeat (4) @(negedge clk);
        check("expect_queue_drained", 32'(exp_q.size()), 32'd0);
        check("sram_queue_drained", 32'(wr_q.size() + rd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
